// File: rtl/router_1xn.sv
// router_1xn: routes parity-terminated packets from one byte stream into N_CH FIFOs, flushing FIFOs left unread too long
module router_1xn #(
  parameter int N_CH = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int TIMEOUT = 30
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pkt_valid,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [N_CH-1:0]        read_enb,
  output logic [N_CH*DATA_W-1:0] data_out,
  output logic [N_CH-1:0]        valid_out,
  output logic                   busy,
  output logic                   err,
  output logic                   drop
);
  localparam int AW = $clog2(N_CH);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int NA = 1 << AW;
  typedef enum logic [2:0] {IDLE, WAIT_EMPTY, LOAD, PARITY_CHK, DROP} state_t;
  state_t st, nxt;
  logic [AW-1:0] addr, addr_in, wr_ch;
  logic [DATA_W-1:0] acc;
  logic [NA-1:0] empty, full, flush;
  logic in_range, wr_en, hdr, drop_set;
  assign addr_in = data_in[AW-1:0];
  assign in_range = 32'(addr_in) < N_CH;
  assign wr_ch = st == IDLE ? addr_in : addr;
  always_comb begin
    nxt = st;
    busy = 1'b0;
    wr_en = 1'b0;
    hdr = 1'b0;
    drop_set = 1'b0;
    case (st)
      IDLE: begin
        if (pkt_valid && !in_range) nxt = DROP;
        else if (pkt_valid && empty[addr_in]) begin
          wr_en = 1'b1;
          hdr = 1'b1;
          nxt = LOAD;
        end else if (pkt_valid) begin
          busy = 1'b1;
          nxt = WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: begin
        busy = !empty[addr];
        wr_en = empty[addr];
        hdr = empty[addr];
        nxt = empty[addr] ? LOAD : WAIT_EMPTY;
      end
      LOAD: begin
        busy = full[addr];
        if (flush[addr]) begin
          drop_set = !busy && !pkt_valid;
          nxt = drop_set ? IDLE : DROP;
        end else if (!busy) begin
          wr_en = 1'b1;
          nxt = pkt_valid ? LOAD : PARITY_CHK;
        end
      end
      PARITY_CHK: begin
        busy = 1'b1;
        nxt = IDLE;
      end
      DROP: begin
        drop_set = !pkt_valid;
        nxt = pkt_valid ? DROP : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= IDLE;
      addr <= '0;
      acc <= '0;
      err <= 1'b0;
      drop <= 1'b0;
    end else begin
      st <= nxt;
      drop <= drop_set;
      if (st == IDLE && pkt_valid) addr <= addr_in;
      acc <= hdr ? data_in : wr_en ? acc ^ data_in : acc;
      if (hdr) err <= 1'b0;
      else if (st == PARITY_CHK) err <= |acc;
    end
  end
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tc;
    logic [DATA_W-1:0] dq;
    logic we, re;
    assign we = wr_en && wr_ch == AW'(k);
    assign re = read_enb[k] && cnt != '0;
    assign empty[k] = cnt == '0;
    assign full[k] = cnt == CW'(DEPTH);
    assign flush[k] = tc == TW'(TIMEOUT);
    assign valid_out[k] = !empty[k];
    assign data_out[k*DATA_W +: DATA_W] = dq;
    always_ff @(posedge clock) if (we) mem[wp] <= data_in;
    always_ff @(posedge clock) begin
      if (reset || flush[k]) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        tc <= '0;
        if (reset) dq <= '0;
      end else begin
        if (we) wp <= wp + PW'(1);
        if (re) rp <= rp + PW'(1);
        if (re) dq <= mem[rp];
        cnt <= cnt + CW'(we) - CW'(re);
        tc <= (empty[k] || read_enb[k]) ? '0 : tc + TW'(1);
      end
    end
  end
  for (genvar k = N_CH; k < NA; k++) begin : g_pad
    assign empty[k] = 1'b0;
    assign full[k] = 1'b0;
    assign flush[k] = 1'b0;
  end
endmodule
